alarm_ctrl_fsm: RTL and testbench

Mode controller and timekeeper that consumes the one-cycle button pulses produced by the five push-button detector chains (debounce → synchronize → rising-edge) and a 1 Hz tick pulse. It keeps clock time (hh:mm:ss) and an alarm time (hh:mm), lets the user adjust either field by field, and raises the alarm-ring flag. Its outputs feed the display multiplexer and the LED/buzzer driver.

---
 rtl/alarm_ctrl_fsm_pkg.sv | 17 +
 rtl/alarm_ctrl_fsm_wrap_counter.sv | 32 +++
 rtl/alarm_ctrl_fsm.sv | 126 ++++++++++++
 tb/tb_alarm_ctrl_fsm.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_ctrl_fsm_pkg.sv
// Shared definitions for the alarm clock: mode encodings, field limits and widths.
package alarm_ctrl_fsm_pkg;

  typedef enum logic [2:0] {
    CLOCK       = 3'd0,
    ADJ_CLK_HR  = 3'd1,
    ADJ_CLK_MIN = 3'd2,
    ADJ_ALM_HR  = 3'd3,
    ADJ_ALM_MIN = 3'd4
  } state_t;

  localparam int unsigned HR_MAX  = 23;
  localparam int unsigned MIN_MAX = 59;
  localparam int unsigned HR_W    = 5;
  localparam int unsigned MIN_W   = 6;

endpackage

// File: rtl/alarm_ctrl_fsm_wrap_counter.sv
// Modulo-(MAX+1) up/down counter with synchronous clear; carry flags the MAX->0 increment.
module wrap_counter #(
  parameter int unsigned MAX = 59,
  parameter int unsigned W   = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] val,
  output logic         carry
);

  logic at_max;

  assign at_max = (val == W'(MAX));
  assign carry  = en & inc & at_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      val <= '0;
    else if (clr)
      val <= '0;
    else if (en && inc)
      val <= at_max ? '0 : val + 1'b1;
    else if (en && dec)
      val <= (val == '0) ? W'(MAX) : val - 1'b1;
  end

endmodule

// File: rtl/alarm_ctrl_fsm.sv
// Alarm clock mode controller: button-driven adjust FSM, timekeeping and alarm ring flag.
module alarm_ctrl_fsm
  import alarm_ctrl_fsm_pkg::*;
#(
  parameter int unsigned RING_SECS = 60
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick_1hz,
  input  logic            btn_c,
  input  logic            btn_u,
  input  logic            btn_d,
  input  logic            btn_l,
  input  logic            btn_r,
  output logic [HR_W-1:0]  disp_hr,
  output logic [MIN_W-1:0] disp_min,
  output logic [MIN_W-1:0] sec,
  output logic [2:0]       mode,
  output logic             adj_led,
  output logic             alarm_ring
);

  localparam int unsigned RW = $clog2(RING_SECS + 1);

  state_t st, st_nxt;
  logic [HR_W-1:0]  clk_hr, alm_hr, nxt_hr;
  logic [MIN_W-1:0] clk_min, alm_min, nxt_min;
  logic [RW-1:0]    ring_cnt;
  logic pc, pr, pl, pu, pd, take, ring_clr, adv;
  logic sec_cy, min_cy, hr_cy, amin_cy, ahr_cy, sec_clr, match;
  logic unused_carries;

  // A pending ring swallows every button; otherwise only the highest-priority pulse acts.
  assign take     = ~alarm_ring;
  assign ring_clr = alarm_ring & (btn_c | btn_u | btn_d | btn_l | btn_r);
  assign pc = take & btn_c;
  assign pr = take & ~btn_c & btn_r;
  assign pl = take & ~btn_c & ~btn_r & btn_l;
  assign pu = take & ~btn_c & ~btn_r & ~btn_l & btn_u;
  assign pd = take & ~btn_c & ~btn_r & ~btn_l & ~btn_u & btn_d;

  assign adv     = tick_1hz & (st == CLOCK);
  assign sec_clr = (pu | pd) & ((st == ADJ_CLK_HR) | (st == ADJ_CLK_MIN));

  always_comb begin
    st_nxt = st;
    case (st)
      CLOCK:       if (pc) st_nxt = ADJ_CLK_HR;
      ADJ_CLK_HR:  if (pc) st_nxt = CLOCK; else if (pr) st_nxt = ADJ_CLK_MIN; else if (pl) st_nxt = ADJ_ALM_MIN;
      ADJ_CLK_MIN: if (pc) st_nxt = CLOCK; else if (pr) st_nxt = ADJ_ALM_HR;  else if (pl) st_nxt = ADJ_CLK_HR;
      ADJ_ALM_HR:  if (pc) st_nxt = CLOCK; else if (pr) st_nxt = ADJ_ALM_MIN; else if (pl) st_nxt = ADJ_CLK_MIN;
      ADJ_ALM_MIN: if (pc) st_nxt = CLOCK; else if (pr) st_nxt = ADJ_CLK_HR;  else if (pl) st_nxt = ADJ_ALM_HR;
      default:     st_nxt = CLOCK;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= CLOCK;
      adj_led <= 1'b0;
    end else begin
      st      <= st_nxt;
      adj_led <= (st_nxt != CLOCK);
    end
  end

  // Field buttons act only in adjust states, where adv is low, so button steps never carry.
  wrap_counter #(.MAX(MIN_MAX), .W(MIN_W)) u_sec (
    .clk(clk), .rst(rst), .inc(adv), .dec(1'b0), .clr(sec_clr), .en(1'b1),
    .val(sec), .carry(sec_cy));

  wrap_counter #(.MAX(MIN_MAX), .W(MIN_W)) u_min (
    .clk(clk), .rst(rst), .inc(sec_cy | ((st == ADJ_CLK_MIN) & pu)),
    .dec((st == ADJ_CLK_MIN) & pd), .clr(1'b0), .en(1'b1),
    .val(clk_min), .carry(min_cy));

  wrap_counter #(.MAX(HR_MAX), .W(HR_W)) u_hr (
    .clk(clk), .rst(rst), .inc((sec_cy & min_cy) | ((st == ADJ_CLK_HR) & pu)),
    .dec((st == ADJ_CLK_HR) & pd), .clr(1'b0), .en(1'b1),
    .val(clk_hr), .carry(hr_cy));

  wrap_counter #(.MAX(MIN_MAX), .W(MIN_W)) u_alm_min (
    .clk(clk), .rst(rst), .inc(pu), .dec(pd), .clr(1'b0), .en(st == ADJ_ALM_MIN),
    .val(alm_min), .carry(amin_cy));

  wrap_counter #(.MAX(HR_MAX), .W(HR_W)) u_alm_hr (
    .clk(clk), .rst(rst), .inc(pu), .dec(pd), .clr(1'b0), .en(st == ADJ_ALM_HR),
    .val(alm_hr), .carry(ahr_cy));

  assign unused_carries = hr_cy ^ amin_cy ^ ahr_cy;

  // Time after this tick; only relevant when sec_cy marks a new hh:mm:00.
  assign nxt_min = (clk_min == MIN_W'(MIN_MAX)) ? '0 : clk_min + 1'b1;
  assign nxt_hr  = (clk_min != MIN_W'(MIN_MAX)) ? clk_hr :
                   (clk_hr == HR_W'(HR_MAX)) ? '0 : clk_hr + 1'b1;
  assign match   = sec_cy & (nxt_min == alm_min) & (nxt_hr == alm_hr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm_ring <= 1'b0;
      ring_cnt   <= '0;
    end else if (match) begin
      alarm_ring <= 1'b1;
      ring_cnt   <= RW'(RING_SECS);
    end else if (ring_clr) begin
      alarm_ring <= 1'b0;
      ring_cnt   <= '0;
    end else if (alarm_ring && tick_1hz) begin
      ring_cnt <= ring_cnt - 1'b1;
      if (ring_cnt == RW'(1))
        alarm_ring <= 1'b0;
    end
  end

  assign mode = st;

  always_comb begin
    disp_hr  = clk_hr;
    disp_min = clk_min;
    if (st == ADJ_ALM_HR || st == ADJ_ALM_MIN) begin
      disp_hr  = alm_hr;
      disp_min = alm_min;
    end
  end

endmodule

// File: tb/tb_alarm_ctrl_fsm.sv
// Randomised and directed bench for alarm_ctrl_fsm against a seconds-of-day reference model.
module tb_alarm_ctrl_fsm;

  localparam int RS = 60;

  logic clk = 1'b0;
  logic rst, tick_1hz, btn_c, btn_u, btn_d, btn_l, btn_r;
  logic [4:0] disp_hr;
  logic [5:0] disp_min, sec;
  logic [2:0] mode;
  logic adj_led, alarm_ring;

  int checks = 0;
  int failures = 0;

  // Reference state: time as seconds of day, alarm as minutes of day.
  int t, alm, md, ring, rcnt;

  alarm_ctrl_fsm #(.RING_SECS(RS)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
    .btn_c(btn_c), .btn_u(btn_u), .btn_d(btn_d), .btn_l(btn_l), .btn_r(btn_r),
    .disp_hr(disp_hr), .disp_min(disp_min), .sec(sec), .mode(mode),
    .adj_led(adj_led), .alarm_ring(alarm_ring));

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    t = 0; alm = 0; md = 0; ring = 0; rcnt = 0;
  endtask

  task automatic model_step(input bit tk, input bit c, input bit u, input bit d,
                            input bit l, input bit r);
    int md0, h, m, dl;
    bit clr, match;
    md0 = md;
    clr = (ring != 0) && (c || u || d || l || r);
    match = 0;
    if (md0 == 0 && tk) begin
      t = (t + 1) % 86400;
      if (t % 60 == 0 && t / 60 == alm) match = 1;
    end
    if (!clr) begin
      h = t / 3600;
      m = (t / 60) % 60;
      if (c) md = (md0 == 0) ? 1 : 0;
      else if (md0 != 0) begin
        if (r) md = md0 % 4 + 1;
        else if (l) md = (md0 + 2) % 4 + 1;
        else if (u || d) begin
          dl = u ? 1 : -1;
          case (md0)
            1: t = ((h + dl + 24) % 24) * 3600 + m * 60;
            2: t = h * 3600 + ((m + dl + 60) % 60) * 60;
            3: alm = ((alm / 60 + dl + 24) % 24) * 60 + alm % 60;
            default: alm = (alm / 60) * 60 + (alm % 60 + dl + 60) % 60;
          endcase
        end
      end
    end
    if (match) begin
      ring = 1; rcnt = RS;
    end else if (clr) begin
      ring = 0; rcnt = 0;
    end else if (ring != 0 && tk) begin
      rcnt--;
      if (rcnt == 0) ring = 0;
    end
  endtask

  function automatic int exp_hr();
    return (md >= 3) ? alm / 60 : t / 3600;
  endfunction

  function automatic int exp_min();
    return (md >= 3) ? alm % 60 : (t / 60) % 60;
  endfunction

  function automatic int exp_vec();
    return (exp_hr() << 17) | (exp_min() << 11) | ((t % 60) << 5) | (md << 2)
         | ((md != 0 ? 1 : 0) << 1) | ring;
  endfunction

  function automatic int obs_vec();
    return int'({disp_hr, disp_min, sec, mode, adj_led, alarm_ring});
  endfunction

  // Called at a falling edge: drive, let one rising edge pass, then compare everything.
  task automatic cyc(input bit tk, input bit c, input bit u, input bit d,
                     input bit l, input bit r);
    tick_1hz = tk; btn_c = c; btn_u = u; btn_d = d; btn_l = l; btn_r = r;
    @(posedge clk);
    model_step(tk, c, u, d, l, r);
    @(negedge clk);
    tick_1hz = 0; btn_c = 0; btn_u = 0; btn_d = 0; btn_l = 0; btn_r = 0;
    check("outs", obs_vec(), exp_vec());
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    tick_1hz = 0; btn_c = 0; btn_u = 0; btn_d = 0; btn_l = 0; btn_r = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_hr", disp_hr, 0);
    check("rst_min", disp_min, 0);
    check("rst_sec", sec, 0);
    check("rst_mode", mode, 0);
    check("rst_led", adj_led, 0);
    check("rst_ring", alarm_ring, 0);
    rst = 1'b0;

    ticks(3661);
    check("t3661_hr", disp_hr, 1);
    check("t3661_min", disp_min, 1);
    check("t3661_sec", sec, 1);

    do_reset();
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    check("dec_hr_mode", mode, 1);
    check("dec_hr_wrap", disp_hr, 23);
    cyc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 60; i++) begin
      cyc(0, 0, 1, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
    end
    check("min_wrap", disp_min, 0);
    check("min_nocarry_hr", disp_hr, 23);
    check("frozen_sec", sec, 0);

    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    ticks(60);
    check("midnight_hr", disp_hr, 0);
    check("midnight_min", disp_min, 0);
    check("midnight_ring", alarm_ring, 1);
    cyc(0, 0, 1, 0, 0, 0);
    check("clr_ring", alarm_ring, 0);
    check("clr_mode", mode, 0);
    check("clr_hr", disp_hr, 0);

    do_reset();
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    check("alm_min_sel", mode, 4);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    check("alm_min_val", disp_min, 2);
    cyc(0, 1, 0, 0, 0, 0);
    ticks(119);
    check("pre_ring", alarm_ring, 0);
    ticks(1);
    check("ring_on", alarm_ring, 1);
    ticks(59);
    check("ring_hold", alarm_ring, 1);
    ticks(1);
    check("ring_off", alarm_ring, 0);

    cyc(0, 1, 1, 0, 0, 0);
    check("cu_mode", mode, 1);
    check("cu_hr", disp_hr, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    check("tick_c_clock_sec", sec, 1);
    check("tick_c_clock_mode", mode, 1);
    cyc(1, 1, 0, 0, 0, 0);
    check("tick_c_adj_sec", sec, 1);
    check("tick_c_adj_mode", mode, 0);

    do_reset();
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 34; i++) cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    ticks(56);
    check("set_sec", sec, 56);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    check("pre_rst_mode", mode, 3);
    #2 rst = 1'b1;
    #1;
    check("async_hr", disp_hr, 0);
    check("async_min", disp_min, 0);
    check("async_sec", sec, 0);
    check("async_mode", mode, 0);
    check("async_led", adj_led, 0);
    check("async_ring", alarm_ring, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 3000; i++)
      cyc(($urandom % 2) == 0, ($urandom % 12) == 0, ($urandom % 6) == 0,
          ($urandom % 6) == 0, ($urandom % 10) == 0, ($urandom % 10) == 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
